// File: rtl/delay_line_pkg.sv
// Shared types and constants for the delay-line measurement sequencer.
//  state_t   : controller FSM states
//  DEF_TAPS  : default number of sampled taps
//  cnt_width : bits needed to hold a count of 0..n inclusive
package delay_line_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_ENCODE = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } state_t;

   localparam int DEF_TAPS = 32;

   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/delay_line_therm_enc.sv
// Combinational thermometer decoder for one captured tap word.
//  taps : captured tap word, tap 0 is nearest the launch point
//  cnt  : number of leading ones from tap 0 (TAPS when all ones)
//  bub  : a 1 exists above the first 0 (does not change cnt)
module delay_line_therm_enc
   import delay_line_pkg::*;
#(
   parameter  int TAPS  = DEF_TAPS,
   localparam int CNT_W = cnt_width(TAPS)
) (
   input  logic [TAPS-1:0]  taps,
   output logic [CNT_W-1:0] cnt,
   output logic             bub
);

   logic             run_s;
   logic [CNT_W-1:0] cnt_s;
   logic             bub_s;

   // Single upward scan: run_s stays high until the first 0, so summing it
   // gives the leading-ones count; any 1 seen after run_s falls is a bubble.
   always_comb begin
      run_s = 1'b1;
      cnt_s = {CNT_W{1'b0}};
      bub_s = 1'b0;
      for (int i = 0; i < TAPS; i++) begin
         bub_s = bub_s | (taps[i] & ~run_s);
         run_s = run_s & taps[i];
         cnt_s = cnt_s + {{(CNT_W-1){1'b0}}, run_s};
      end
   end

   assign cnt = cnt_s;
   assign bub = bub_s;

endmodule

// File: rtl/delay_line_ctrl.sv
// Measurement sequencer for a tapped delay line: launches an edge, captures
// the taps one clock later, decodes them and accumulates 2**AVG_LOG2 samples.
//  clk, rst_n : clock, asynchronous active-low reset
//  ena        : design selected; low aborts any run on the next edge
//  start_i    : start request, honoured only in IDLE
//  taps_i     : raw tap outputs of the delay line
//  launch_o   : edge driven into the delay line (one cycle per sample)
//  busy_o     : high whenever a run is in progress
//  done_o     : one-cycle pulse when result_o updates
//  result_o   : sum of the decoded samples of the last completed run
//  bubble_o   : sticky per run, a bubble was seen in some sample
module delay_line_ctrl
   import delay_line_pkg::*;
#(
   parameter  int TAPS     = DEF_TAPS,
   parameter  int AVG_LOG2 = 3,
   parameter  int SETTLE   = 2,
   localparam int CNT_W    = cnt_width(TAPS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      ena,
   input  logic                      start_i,
   input  logic [TAPS-1:0]           taps_i,
   output logic                      launch_o,
   output logic                      busy_o,
   output logic                      done_o,
   output logic [CNT_W+AVG_LOG2-1:0] result_o,
   output logic                      bubble_o
);

   localparam int RES_W = CNT_W + AVG_LOG2;
   localparam int SMP_W = AVG_LOG2 + 1;
   localparam int N_SMP = 1 << AVG_LOG2;
   localparam int SET_W = cnt_width(SETTLE);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [SET_W-1:0] settle_r;
   logic [SMP_W-1:0] smp_r;
   logic [TAPS-1:0]  tap_q_r;
   logic [RES_W-1:0] acc_r;
   logic [RES_W-1:0] result_r;
   logic             bubble_r;
   logic             launch_r;
   logic             busy_r;
   logic             done_r;
   logic [CNT_W-1:0] cnt_s;
   logic             bub_s;

   delay_line_therm_enc #(.TAPS(TAPS)) u_enc (
      .taps (tap_q_r),
      .cnt  (cnt_s),
      .bub  (bub_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; ena low overrides every transition.
   always_comb begin
      state_nxt_s = ST_IDLE;
      if (!ena) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_i) state_nxt_s = ST_LAUNCH;
               else         state_nxt_s = ST_IDLE;
            end
            ST_LAUNCH: state_nxt_s = ST_ENCODE;
            ST_ENCODE: state_nxt_s = ST_DRAIN;
            ST_DRAIN: begin
               if (settle_r != {SET_W{1'b0}})        state_nxt_s = ST_DRAIN;
               else if (smp_r == SMP_W'(N_SMP))      state_nxt_s = ST_DONE;
               else                                  state_nxt_s = ST_LAUNCH;
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Datapath: tap capture, accumulation, sample and settle counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_r <= {SET_W{1'b0}};
         smp_r    <= {SMP_W{1'b0}};
         tap_q_r  <= {TAPS{1'b0}};
         acc_r    <= {RES_W{1'b0}};
         bubble_r <= 1'b0;
      end else if (ena) begin
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  acc_r    <= {RES_W{1'b0}};
                  smp_r    <= {SMP_W{1'b0}};
                  bubble_r <= 1'b0;
               end
            end
            // Taps are captured on the edge that ends the launch cycle.
            ST_LAUNCH: tap_q_r <= taps_i;
            ST_ENCODE: begin
               acc_r    <= acc_r + RES_W'(cnt_s);
               bubble_r <= bubble_r | bub_s;
               smp_r    <= smp_r + SMP_W'(1);
               settle_r <= SET_W'(SETTLE - 1);
            end
            ST_DRAIN: begin
               if (settle_r != {SET_W{1'b0}}) settle_r <= settle_r - SET_W'(1);
            end
            default: settle_r <= settle_r;
         endcase
      end
   end

   // Output registers follow the next state so they line up with state_r.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         launch_r <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= {RES_W{1'b0}};
      end else begin
         launch_r <= (state_nxt_s == ST_LAUNCH);
         busy_r   <= (state_nxt_s != ST_IDLE);
         done_r   <= (state_nxt_s == ST_DONE);
         if (state_nxt_s == ST_DONE) result_r <= acc_r;
      end
   end

   assign launch_o = launch_r;
   assign busy_o   = busy_r;
   assign done_o   = done_r;
   assign result_o = result_r;
   assign bubble_o = bubble_r;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Scoreboard bench for delay_line_ctrl (TAPS=32, AVG_LOG2=3, SETTLE=2).
module tb_delay_line_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic        start_i;
   logic [31:0] taps_i;
   logic        launch_o;
   logic        busy_o;
   logic        done_o;
   logic [8:0]  result_o;
   logic        bubble_o;

   delay_line_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ena      (ena),
      .start_i  (start_i),
      .taps_i   (taps_i),
      .launch_o (launch_o),
      .busy_o   (busy_o),
      .done_o   (done_o),
      .result_o (result_o),
      .bubble_o (bubble_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int res;
      int bub;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks    = 0;
   int   n_fail      = 0;
   int   launch_hi   = 0;
   int   launch_rise = 0;
   logic launch_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Issue a start from IDLE; done is due 32 edges after the accepting edge.
   task automatic launch_run(input logic [31:0] t, input int res, input int bub);
      exp_t e;
      taps_i  = t;
      start_i = 1'b1;
      e.res = res;
      e.bub = bub;
      e.cyc = cyc + 33;
      sb.push_back(e);
      step(1);
      start_i = 1'b0;
   endtask

   task automatic wait_drain(input int budget);
      int i;
      i = 0;
      while (sb.size() != 0 && i < budget) begin
         @(posedge clk);
         i++;
      end
      #1;
      check("run_completed", (sb.size() == 0), 1);
      sb.delete();
   endtask

   // Monitor: counts launch pulses and scores every done_o against the queue.
   initial begin
      exp_t e;
      int   depth;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            if (launch_o === 1'b1) begin
               launch_hi++;
               if (launch_prev !== 1'b1) launch_rise++;
            end
            launch_prev = launch_o;
            if (done_o === 1'b1) begin
               depth = sb.size();
               check("done_expected", (depth > 0), 1);
               if (depth > 0) begin
                  e = sb.pop_front();
                  check("result", result_o, e.res);
                  check("bubble", bubble_o, e.bub);
                  check("done_cycle", cyc, e.cyc);
               end
            end
         end else begin
            launch_prev = 1'b0;
         end
      end
   end

   initial begin
      rst_n   = 1'b0;
      ena     = 1'b1;
      start_i = 1'b0;
      taps_i  = 32'h0;
      step(3);
      check("rst_launch", launch_o, 0);
      check("rst_busy",   busy_o,   0);
      check("rst_done",   done_o,   0);
      check("rst_result", result_o, 0);
      check("rst_bubble", bubble_o, 0);
      rst_n = 1'b1;
      step(2);

      // 1: eight leading ones, 8 samples -> 64, eight launch pulses
      launch_hi   = 0;
      launch_rise = 0;
      launch_run(32'h0000_00FF, 64, 0);
      check("busy_running", busy_o, 1);
      wait_drain(100);
      check("launch_cycles", launch_hi, 8);
      check("launch_pulses", launch_rise, 8);
      step(1);
      check("idle_after_done", busy_o, 0);

      // 2: saturation and empty line
      launch_run(32'hFFFF_FFFF, 256, 0);
      wait_drain(100);
      launch_run(32'h0000_0000, 0, 0);
      wait_drain(100);

      // 3: bubble pattern, then bubble flag cleared by the next run
      launch_run(32'h0000_0F0F, 32, 1);
      wait_drain(100);
      launch_run(32'h0000_000F, 32, 0);
      wait_drain(100);

      // 4: ena dropped in the third DRAIN -> abort without done
      taps_i  = 32'h0000_00FF;
      start_i = 1'b1;
      step(1);
      start_i = 1'b0;
      step(10);
      check("abort_busy_before", busy_o, 1);
      ena = 1'b0;
      step(1);
      check("abort_busy",   busy_o,   0);
      check("abort_launch", launch_o, 0);
      check("abort_done",   done_o,   0);
      check("abort_result", result_o, 32);
      step(40);
      ena = 1'b1;
      step(1);
      launch_run(32'h0000_0007, 24, 0);
      wait_drain(100);

      // 5: start pulsed while busy is dropped; held start re-triggers after one IDLE cycle
      begin
         exp_t e;
         taps_i  = 32'h0000_03FF;
         start_i = 1'b1;
         e.res = 80;
         e.bub = 0;
         e.cyc = cyc + 33;
         sb.push_back(e);
         e.cyc = cyc + 67;
         sb.push_back(e);
         step(1);
         start_i = 1'b0;
         step(9);
         start_i = 1'b1;
         step(1);
         start_i = 1'b0;
         step(19);
         start_i = 1'b1;
         step(5);
         start_i = 1'b0;
         wait_drain(120);
         step(40);
      end

      // 6: reset in LAUNCH clears outputs before the next edge
      taps_i  = 32'h0000_0001;
      start_i = 1'b1;
      step(1);
      start_i = 1'b0;
      check("pre_rst_launch", launch_o, 1);
      check("pre_rst_result", result_o, 80);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_launch", launch_o, 0);
      check("async_rst_busy",   busy_o,   0);
      check("async_rst_result", result_o, 0);
      step(2);
      rst_n = 1'b1;
      step(1);
      launch_run(32'h0000_0001, 8, 0);
      wait_drain(100);
      step(5);
      check("final_queue_empty", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
